// File: rtl/sound_mixer_lr.sv
`default_nettype none
// ============================================================================
// Module   : sound_mixer_lr
// Purpose  : Snapshots the four channel outputs on a sample tick, routes them to
//            the left/right buses and scales each bus by its master volume.
// Revision : 1.0
// ============================================================================
module sound_mixer_lr (
  input  logic       iClock,
  input  logic       iReset_n,
  input  logic       iSampleTick,
  input  logic [4:0] iCh1,
  input  logic [4:0] iCh2,
  input  logic [4:0] iCh3,
  input  logic [4:0] iCh4,
  input  logic [7:0] iNR50,
  input  logic [7:0] iNR51,
  input  logic [7:0] iNR52,
  output logic [9:0] oLeft,
  output logic [9:0] oRight,
  output logic       oSampleValid,
  output logic       oBusy,
  output logic       oOverrun
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    ACC0    = 3'd2,
    ACC1    = 3'd3,
    ACC2    = 3'd4,
    ACC3    = 3'd5,
    SCALE   = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;

  logic [4:0]  r_ch [4];
  logic [2:0]  r_volL;
  logic [2:0]  r_volR;
  logic [7:0]  r_nr51;
  logic [6:0]  r_accL;
  logic [6:0]  r_accR;
  logic [9:0]  r_prodL;
  logic [9:0]  r_prodR;
  logic [9:0]  r_left;
  logic [9:0]  r_right;
  logic        r_valid;
  logic        r_overrun;

  logic        w_enable;
  logic        w_accStep;
  logic [1:0]  w_idx;
  logic [4:0]  w_chSel;
  logic [5:0]  w_delta;
  logic [6:0]  w_deltaExt;
  logic        w_routeL;
  logic        w_routeR;
  logic [3:0]  w_volL;
  logic [3:0]  w_volR;
  logic [11:0] w_prodLFull;
  logic [11:0] w_prodRFull;
  logic        w_unused;

  assign w_enable = iNR52[7];

  // Next-state logic; a dropped master enable overrides every state.
  always_comb begin
    w_stateNext = r_state;
    if (!w_enable) begin
      w_stateNext = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (iSampleTick) w_stateNext = CAPTURE;
        CAPTURE: w_stateNext = ACC0;
        ACC0:    w_stateNext = ACC1;
        ACC1:    w_stateNext = ACC2;
        ACC2:    w_stateNext = ACC3;
        ACC3:    w_stateNext = SCALE;
        SCALE:   w_stateNext = DONE;
        DONE:    w_stateNext = IDLE;
        default: w_stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_accStep = 1'b0;
    w_idx     = 2'd0;
    case (r_state)
      ACC0:    begin w_accStep = 1'b1; w_idx = 2'd0; end
      ACC1:    begin w_accStep = 1'b1; w_idx = 2'd1; end
      ACC2:    begin w_accStep = 1'b1; w_idx = 2'd2; end
      ACC3:    begin w_accStep = 1'b1; w_idx = 2'd3; end
      default: begin w_accStep = 1'b0; w_idx = 2'd0; end
    endcase
  end

  // Offset-binary to signed: a code of 31 becomes +16 with no clamp.
  assign w_chSel    = r_ch[w_idx];
  assign w_delta    = {1'b0, w_chSel} - 6'd15;
  assign w_deltaExt = {w_delta[5], w_delta};
  assign w_routeL   = r_nr51[{1'b1, w_idx}];
  assign w_routeR   = r_nr51[{1'b0, w_idx}];

  // Modulo-2^12 product of a sign-extended accumulator equals the signed product.
  assign w_volL      = {1'b0, r_volL} + 4'd1;
  assign w_volR      = {1'b0, r_volR} + 4'd1;
  assign w_prodLFull = {{5{r_accL[6]}}, r_accL} * {8'd0, w_volL};
  assign w_prodRFull = {{5{r_accR[6]}}, r_accR} * {8'd0, w_volR};

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int i = 0; i < 4; i++) r_ch[i] <= 5'd0;
      r_volL  <= 3'd0;
      r_volR  <= 3'd0;
      r_nr51  <= 8'd0;
      r_accL  <= 7'd0;
      r_accR  <= 7'd0;
      r_prodL <= 10'd0;
      r_prodR <= 10'd0;
      r_left  <= 10'd0;
      r_right <= 10'd0;
      r_valid <= 1'b0;
    end else if (!w_enable) begin
      r_left  <= 10'd0;
      r_right <= 10'd0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        CAPTURE: begin
          r_ch[0] <= iCh1;
          r_ch[1] <= iCh2;
          r_ch[2] <= iCh3;
          r_ch[3] <= iCh4;
          r_volL  <= iNR50[6:4];
          r_volR  <= iNR50[2:0];
          r_nr51  <= iNR51;
          r_accL  <= 7'd0;
          r_accR  <= 7'd0;
        end
        SCALE: begin
          r_prodL <= w_prodLFull[9:0];
          r_prodR <= w_prodRFull[9:0];
        end
        DONE: begin
          r_left  <= r_prodL;
          r_right <= r_prodR;
          r_valid <= 1'b1;
        end
        default: begin
          if (w_accStep) begin
            if (w_routeL) r_accL <= r_accL + w_deltaExt;
            if (w_routeR) r_accR <= r_accR + w_deltaExt;
          end
        end
      endcase
    end
  end

  // Ticks are only dropped (and flagged) while the mixer is enabled and busy.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_overrun <= 1'b0;
    end else if (w_enable && iSampleTick && (r_state != IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  assign oLeft        = r_left;
  assign oRight       = r_right;
  assign oSampleValid = r_valid;
  assign oBusy        = (r_state != IDLE);
  assign oOverrun     = r_overrun;

  assign w_unused = &{1'b0, iNR50[7], iNR50[3], iNR52[6:0],
                      w_prodLFull[11:10], w_prodRFull[11:10]};

endmodule
`default_nettype wire
